// File: rtl/system_uart_rx_pkg.sv
// Shared definitions for the UART receiver: the data width, the FSM state encoding,
// the parity-type codes and a 3-input majority helper.
package system_uart_rx_pkg;

  // Data bits per frame.
  localparam int unsigned WIDTH = 8;

  // Receiver FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  // Parity type codes as seen on i_par_type.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Majority of three samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/system_uart_rx_rx_sampler.sv
// Bit sampler for the UART receiver.
// Synchronises the serial line, runs the per-bit edge counter and takes three samples
// around the bit centre; the voted bit is presented with a strobe on the last edge of
// each bit period.
// Ports:
//   i_clk         clock (PRESCALE x baud)
//   i_rst         asynchronous active-low reset
//   i_rx          raw serial line, asynchronous to i_clk
//   i_clear       holds the edge counter and samples cleared (FSM idle)
//   o_rx_s        synchronised serial line
//   o_bit         majority of the three samples of the current bit
//   o_bit_strobe  high for the last clock of each bit period
module system_uart_rx_rx_sampler
  import system_uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_clear,
  output logic o_rx_s,
  output logic o_bit,
  output logic o_bit_strobe
);

  localparam int unsigned EcW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [EcW-1:0] EcLast = EcW'(PRESCALE - 1);
  localparam logic [EcW-1:0] EcS0   = EcW'(PRESCALE / 2 - 1);
  localparam logic [EcW-1:0] EcS1   = EcW'(PRESCALE / 2);
  localparam logic [EcW-1:0] EcS2   = EcW'(PRESCALE / 2 + 1);

  logic           r_sync1;
  logic           r_rx_s;
  logic [EcW-1:0] r_ec;
  logic [2:0]     r_smp;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ec  <= '0;
      r_smp <= '0;
    end else if (i_clear) begin
      r_ec  <= '0;
      r_smp <= '0;
    end else begin
      r_ec <= (r_ec == EcLast) ? '0 : r_ec + 1'b1;
      if (r_ec == EcS0) r_smp[0] <= r_rx_s;
      if (r_ec == EcS1) r_smp[1] <= r_rx_s;
      if (r_ec == EcS2) r_smp[2] <= r_rx_s;
    end
  end

  assign o_rx_s       = r_rx_s;
  assign o_bit        = maj3(r_smp);
  assign o_bit_strobe = !i_clear && (r_ec == EcLast);

endmodule

// File: rtl/system_uart_rx.sv
// UART receiver top level.
// Receives start(0), WIDTH data bits LSB first, optional parity, stop(1). The sampler
// supplies one majority-voted bit per bit period; this level runs the frame FSM, the
// bit counter, the shift register and parity check, and registers the result pulses.
// Ports:
//   i_clk         clock (PRESCALE x baud)
//   i_rst         asynchronous active-low reset
//   i_rx          serial line, idles high
//   i_en_par      1: frame carries a parity bit (latched at frame start)
//   i_par_type    0: even, 1: odd (latched at frame start)
//   o_data        last good word, held until the next good frame
//   o_data_valid  1-cycle pulse when o_data is updated
//   o_par_err     1-cycle pulse on parity mismatch
//   o_stop_err    1-cycle pulse when the stop bit is sampled 0
//   o_busy        high whenever the FSM is not idle
module system_uart_rx
  import system_uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  input  logic             i_en_par,
  input  logic             i_par_type,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid,
  output logic             o_par_err,
  output logic             o_stop_err,
  output logic             o_busy
);

  if (PRESCALE < 4 || (PRESCALE % 2) != 0) begin : g_bad_prescale
    $error("PRESCALE must be even and >= 4");
  end

  localparam int unsigned BcW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BcW-1:0] BcLast = BcW'(WIDTH - 1);

  state_e           r_state;
  logic [BcW-1:0]   r_bc;
  logic [WIDTH-1:0] r_shreg;
  logic             r_en_par;
  logic             r_par_type;
  logic             r_par_mis;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_par_err;
  logic             r_stop_err;

  logic w_rx_s;
  logic w_bit;
  logic w_strobe;
  logic w_clear;

  assign w_clear = (r_state == StIdle);

  system_uart_rx_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_clear     (w_clear),
    .o_rx_s      (w_rx_s),
    .o_bit       (w_bit),
    .o_bit_strobe(w_strobe)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_bc         <= '0;
      r_shreg      <= '0;
      r_en_par     <= 1'b0;
      r_par_type   <= 1'b0;
      r_par_mis    <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      // Result outputs are single-cycle pulses.
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_rx_s) begin
            r_state    <= StStart;
            // Frame format is frozen for the whole frame.
            r_en_par   <= i_en_par;
            r_par_type <= i_par_type;
            r_par_mis  <= 1'b0;
          end
        end
        StStart: begin
          if (w_strobe) begin
            if (w_bit) begin
              // Start bit did not hold low: treat as a line glitch.
              r_state <= StIdle;
            end else begin
              r_state <= StData;
              r_bc    <= '0;
            end
          end
        end
        StData: begin
          if (w_strobe) begin
            r_shreg <= {w_bit, r_shreg[WIDTH-1:1]};
            if (r_bc == BcLast) begin
              r_state <= r_en_par ? StParity : StStop;
            end else begin
              r_bc <= r_bc + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_strobe) begin
            r_par_mis <= ((^r_shreg) ^ (r_par_type == PAR_ODD)) != w_bit;
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_strobe) begin
            if (w_bit) begin
              if (!r_par_mis) begin
                r_data       <= r_shreg;
                r_data_valid <= 1'b1;
              end else begin
                r_par_err <= 1'b1;
              end
            end else begin
              r_stop_err <= 1'b1;
              r_par_err  <= r_par_mis;
            end
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stop_err   = r_stop_err;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_system_uart_rx.sv
module tb_system_uart_rx;
  import system_uart_rx_pkg::*;

  localparam int unsigned P = 8;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_rx = 1'b1;
  logic             i_en_par = 1'b0;
  logic             i_par_type = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_data_valid;
  logic             o_par_err;
  logic             o_stop_err;
  logic             o_busy;

  system_uart_rx #(
    .PRESCALE(P)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_en_par    (i_en_par),
    .i_par_type  (i_par_type),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_par_err   (o_par_err),
    .o_stop_err  (o_stop_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Expected pulse kind as {valid, par_err, stop_err} and the o_data seen with it.
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_last = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every result pulse is matched against the head of the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst && (o_data_valid || o_par_err || o_stop_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'({o_data_valid, o_par_err, o_stop_err}), 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 32'({o_data_valid, o_par_err, o_stop_err}), 32'(e.kind));
        chk("pulse_data", 32'(o_data), 32'(e.data));
      end
    end
  end

  task automatic hold(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic gap(input int bits);
    hold(1'b1, bits * P);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
    chk({tag, "_pulses"}, 32'({o_data_valid, o_par_err, o_stop_err}), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  // Sends one frame. flip_par corrupts the parity bit; stop_v is the stop-bit level;
  // glitch_bit puts a one-clock inverted pulse mid-bit; abort_bit resets mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic en, input logic pt,
                            input logic flip_par, input logic stop_v,
                            input int glitch_bit, input int abort_bit);
    logic pbit;
    logic mis;
    exp_t e;
    pbit = (($countones(d) % 2) == 1) ^ pt ^ flip_par;
    mis  = en && flip_par;
    if (abort_bit < 0) begin
      if (stop_v && !mis) begin
        e.kind = 3'b100;
        e.data = d;
        m_last = d;
      end else begin
        e.kind = stop_v ? 3'b010 : (mis ? 3'b011 : 3'b001);
        e.data = m_last;
      end
      q.push_back(e);
    end
    i_en_par   = en;
    i_par_type = pt;
    hold(1'b0, P);
    // Mid-frame format changes must be ignored.
    i_en_par   = 1'($urandom);
    i_par_type = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) chk("busy_mid_frame", 32'(o_busy), 32'd1);
      if (i == abort_bit) begin
        hold(d[i], 3);
        i_rst = 1'b0;
        #1;
        reset_checks("mid_reset");
        i_rx = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst  = 1'b1;
        m_last = 8'h00;
        return;
      end
      if (i == glitch_bit) begin
        hold(d[i], 4);
        hold(~d[i], 1);
        hold(d[i], P - 5);
      end else begin
        hold(d[i], P);
      end
    end
    if (en) hold(pbit, P);
    hold(stop_v, P);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge i_clk);
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       en, pt, fp, sv;
    int         g;
    bit         prev_gap0;

    repeat (3) @(negedge i_clk);
    #1;
    reset_checks("reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    gap(2);

    // Parity off.
    chk("busy_before", 32'(o_busy), 32'd0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    gap(2);
    drain("t1");
    chk("busy_after", 32'(o_busy), 32'd0);

    // Even parity good then bad.
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, -1);
    gap(2);
    send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1, -1);
    gap(2);
    drain("t2");

    // Odd parity; 0x01 carries parity bit 0.
    send_frame(8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, -1);
    gap(2);
    drain("t3");

    // Stop bit low, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    gap(2);
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    gap(2);
    drain("t4");

    // Short low glitch: no frame, back to idle.
    hold(1'b0, 2);
    gap(3);
    chk("glitch_idle", 32'(o_busy), 32'd0);
    // One-clock glitch mid data bit is voted out.
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
    gap(2);
    drain("t5");

    // Back-to-back frames.
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(8'h56, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    gap(2);
    drain("t6a");

    // Reset in data bit 4, then a clean frame.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4);
    gap(2);
    send_frame(8'h9A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    gap(2);
    drain("t6b");

    // Randomised frames.
    prev_gap0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      en = 1'($urandom);
      pt = 1'($urandom);
      fp = en && ($urandom_range(3) == 0);
      sv = ($urandom_range(5) != 0);
      send_frame(d, en, pt, fp, sv, -1, -1);
      g = prev_gap0 ? 1 + int'($urandom_range(1)) : int'($urandom_range(2));
      prev_gap0 = (g == 0);
      gap(g);
    end
    gap(2);
    drain("random");
    chk("final_data", 32'(o_data), 32'(m_last));
    chk("final_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
